fifo_drain_ctrl: RTL and testbench
==================================

# fifo_drain_ctrl

Read-side controller for the 16-bit sample FIFO fed by the ADC write path. On a start request it drains exactly one frame of samples from the FIFO and delivers them in order to the FIR filter block through a valid/ready stream. A two-entry output buffer absorbs the FIFO's one-cycle read latency, so the block sustains one sample per cycle under no backpressure.

## Interface
- DATA_W, 16, sample width.
- FRAME_LEN, 1024, samples per frame (≥1).
- CNT_W, 11, width of count_o; must hold FRAME_LEN.

- clk_i  input  1  system clock, 78 MHz; all logic on rising edge.
- rst_i  input  1  asynchronous, active-low reset.
- start_i  input  1  frame request; sampled only in IDLE.
- abort_i  input  1  cancel the current frame.
- fifo_dout_i  input  DATA_W  FIFO read data, valid the cycle after fifo_rd_en_o.
- fifo_empty_i  input  1  FIFO empty flag.
- fifo_rd_en_o  output  1  FIFO read strobe (combinational).
- m_data_o  output  DATA_W  sample to FIR; 0 whenever m_valid_o=0.
- m_valid_o  output  1  m_data_o valid.
- m_ready_i  input  1  FIR accepts the sample.
- busy_o  output  1  state ≠ IDLE.
- done_o  output  1  one-cycle pulse when a frame completes.
- count_o  output  CNT_W  samples handed off in the current or last frame.
- underrun_o  output  1  sticky: downstream starved by an empty FIFO during this frame.

## Operation
- States: IDLE, RUN, DRAIN.
- IDLE→RUN: start_i=1 and abort_i=0. Clears count_o, issued counter, and underrun_o.
- RUN→IDLE: handshake (m_valid_o & m_ready_i) that brings count_o to FRAME_LEN. done_o pulses the next cycle.
- RUN→DRAIN: abort_i=1. Reads stop immediately, the buffer is flushed, m_valid_o=0 from the next cycle.
- DRAIN→IDLE: unconditionally after one cycle. Any in-flight read data is discarded. done_o is not pulsed.
- abort_i in IDLE or DRAIN has no effect. start_i while busy is ignored. If start_i and abort_i are both high in IDLE, abort_i wins.
- Read issue condition: fifo_rd_en_o = RUN & !fifo_empty_i & (issued < FRAME_LEN) & (occ + inflight − pop < 2).
  - occ is buffer occupancy (0..2).
  - inflight is 1 if fifo_rd_en_o was high in the previous cycle.
  - pop = m_valid_o & m_ready_i.
- Buffer is FIFO-ordered. The head drives m_data_o (registered). The sample is written one cycle after its read strobe.
- m_data_o and m_valid_o hold stable while m_valid_o=1 and m_ready_i=0.
- count_o increments on each pop and holds its final value in IDLE until the next accepted start.
- underrun_o is set in RUN when fifo_empty_i=1, issued < FRAME_LEN, occ=0, and inflight=0.
- Reset: state IDLE, buffer empty, and all outputs 0, including fifo_rd_en_o (combinationally, since state=IDLE). Reset asserted mid-frame abandons the frame with no done_o.

## Timing
- start_i sampled at edge E0. fifo_rd_en_o can be high in the cycle after E0. The sample is buffered at E2, and m_valid_o=1 after E2. Start-to-first-valid is 2 cycles.
- Steady state with a non-empty FIFO and m_ready_i=1: one read and one handoff per cycle.
- Last handshake at edge En, then done_o=1 and busy_o=0 for the cycle after En.
- Backpressure reaches fifo_rd_en_o combinationally through m_ready_i (pop term).
- abort_i sampled at edge Ea, then m_valid_o=0 and fifo_rd_en_o=0 after Ea. busy_o=0 after Ea+1.

## Test plan
- Reset: assert rst_i=0 asynchronously mid-cycle with random inputs → all outputs 0 immediately. Release → IDLE, busy_o=0.
- Full rate, FRAME_LEN=8: FIFO preloaded 1..8, m_ready_i=1, start pulse.
  - fifo_rd_en_o high for 8 consecutive cycles.
  - m_data_o = 1..8 on consecutive cycles, first valid 2 cycles after start.
  - done_o single pulse, count_o=8, underrun_o=0.
- Backpressure, FRAME_LEN=8: m_ready_i pattern 1,0,0,1,0,1….
  - Delivered sequence is exactly 1..8, with no duplicates or drops.
  - Data is stable while stalled.
  - occ + inflight never exceeds 2.
- Underrun, FRAME_LEN=8, FIFO holds 3 samples.
  - 3 samples delivered, then underrun_o=1 and busy_o=1.
  - Push 5 more → all delivered, done_o pulses, count_o=8, underrun_o stays 1.
- Abort: abort_i after 4 handshakes.
  - m_valid_o=0 next cycle, no done_o, busy_o=0 two cycles after abort, count_o=4.
  - A new start delivers the next FIFO samples in order, with underrun_o cleared.
- Simultaneous start_i and abort_i in IDLE → stays IDLE, no fifo_rd_en_o.

Source files
------------

// File: rtl/fifo_drain_ctrl.sv
// Purpose: read-side controller draining one FRAME_LEN-sample frame from the ADC sample FIFO into a valid/ready stream for the FIR.
// Latency: start sampled at E0, FIFO read in the next cycle, first m_valid_o after E2 (2 cycles); 1 sample/cycle sustained.
// Backpressure: m_ready_i reaches fifo_rd_en_o combinationally; a 2-entry buffer plus the in-flight read never exceed 2 samples.
//
// Ports:
//   clk_i, rst_i                 clock, asynchronous active-low reset
//   start_i, abort_i             frame request (IDLE only) / cancel current frame
//   fifo_dout_i, fifo_empty_i    FIFO read data (valid the cycle after the strobe) and empty flag
//   fifo_rd_en_o                 FIFO read strobe (combinational)
//   m_data_o, m_valid_o, m_ready_i  sample stream to the FIR; data forced to 0 when not valid
//   busy_o, done_o               not-IDLE / one-cycle frame-complete pulse
//   count_o, underrun_o          samples handed off this frame / sticky starvation flag
module fifo_drain_ctrl #(
    parameter int DATA_W    = 16,
    parameter int FRAME_LEN = 1024,
    parameter int CNT_W     = 11
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic              abort_i,
    input  logic [DATA_W-1:0] fifo_dout_i,
    input  logic              fifo_empty_i,
    output logic              fifo_rd_en_o,
    output logic [DATA_W-1:0] m_data_o,
    output logic              m_valid_o,
    input  logic              m_ready_i,
    output logic              busy_o,
    output logic              done_o,
    output logic [CNT_W-1:0]  count_o,
    output logic              underrun_o
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    localparam logic [CNT_W-1:0] LAST = CNT_W'(FRAME_LEN);

    logic [1:0]        state;
    logic [CNT_W-1:0]  issued;
    logic [CNT_W-1:0]  count_q;
    logic [1:0]        occ;
    logic              inflight;
    logic [DATA_W-1:0] buf0;
    logic [DATA_W-1:0] buf1;
    logic              done_q;
    logic              underrun_q;

    logic run;
    logic pop;
    logic room;
    logic frame_end;

    assign run       = (state == ST_RUN);
    assign m_valid_o = (occ != 2'd0);
    assign m_data_o  = m_valid_o ? buf0 : '0;
    assign pop       = m_valid_o & m_ready_i;

    // A new read is allowed only if, after this cycle's pop, the buffer can
    // still hold every sample already requested plus the one issued now.
    assign room = ({1'b0, occ} + {2'b00, inflight}) < (3'd2 + {2'b00, pop});

    assign fifo_rd_en_o = run & ~fifo_empty_i & (issued < LAST) & room;

    assign frame_end = run & pop & ((count_q + CNT_W'(1)) == LAST);

    assign busy_o     = (state != ST_IDLE);
    assign done_o     = done_q;
    assign count_o    = count_q;
    assign underrun_o = underrun_q;

    // Control state, counters and status flags.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state      <= ST_IDLE;
            issued     <= '0;
            count_q    <= '0;
            inflight   <= 1'b0;
            done_q     <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            done_q   <= 1'b0;
            inflight <= fifo_rd_en_o;
            case (state)
                ST_IDLE: begin
                    if (start_i && !abort_i) begin
                        state      <= ST_RUN;
                        issued     <= '0;
                        count_q    <= '0;
                        underrun_q <= 1'b0;
                    end
                end
                ST_RUN: begin
                    if (fifo_rd_en_o) begin
                        issued <= issued + CNT_W'(1);
                    end
                    if (pop) begin
                        count_q <= count_q + CNT_W'(1);
                    end
                    // Starved: nothing buffered, nothing on its way, and the
                    // FIFO cannot supply the samples still owed.
                    if (fifo_empty_i && (issued < LAST) && (occ == 2'd0) && !inflight) begin
                        underrun_q <= 1'b1;
                    end
                    // The final handshake completes the frame even if abort
                    // arrives in the same cycle.
                    if (frame_end) begin
                        state  <= ST_IDLE;
                        done_q <= 1'b1;
                    end else if (abort_i) begin
                        state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    // One cycle lets a read issued in the abort cycle land
                    // here, where it is dropped.
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Two-entry output buffer; buf0 is the head. FIFO data is written the
    // cycle after its strobe (inflight) and only while running.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            occ  <= 2'd0;
            buf0 <= '0;
            buf1 <= '0;
        end else if (!run || abort_i) begin
            occ <= 2'd0;
        end else begin
            case ({inflight, pop})
                2'b10: begin
                    if (occ == 2'd0) begin
                        buf0 <= fifo_dout_i;
                    end else begin
                        buf1 <= fifo_dout_i;
                    end
                    occ <= occ + 2'd1;
                end
                2'b01: begin
                    buf0 <= buf1;
                    occ  <= occ - 2'd1;
                end
                2'b11: begin
                    if (occ == 2'd1) begin
                        buf0 <= fifo_dout_i;
                    end else begin
                        buf0 <= buf1;
                        buf1 <= fifo_dout_i;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_drain_ctrl.sv
// Purpose: self-checking bench for fifo_drain_ctrl with FRAME_LEN=8.
// Latency: expected samples queued at frame start, checked by a negedge monitor on each handshake.
// Backpressure: directed m_ready_i patterns; monitor checks stall stability and the 2-sample outstanding limit.
module tb_fifo_drain_ctrl;

    localparam int DW = 16;
    localparam int FL = 8;
    localparam int CW = 4;

    logic          clk_i        = 1'b0;
    logic          rst_i        = 1'b0;
    logic          start_i      = 1'b0;
    logic          abort_i      = 1'b0;
    logic [DW-1:0] fifo_dout_i  = '0;
    logic          fifo_empty_i = 1'b1;
    logic          m_ready_i    = 1'b0;
    logic          fifo_rd_en_o;
    logic [DW-1:0] m_data_o;
    logic          m_valid_o;
    logic          busy_o;
    logic          done_o;
    logic [CW-1:0] count_o;
    logic          underrun_o;

    fifo_drain_ctrl #(.DATA_W(DW), .FRAME_LEN(FL), .CNT_W(CW)) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .start_i      (start_i),
        .abort_i      (abort_i),
        .fifo_dout_i  (fifo_dout_i),
        .fifo_empty_i (fifo_empty_i),
        .fifo_rd_en_o (fifo_rd_en_o),
        .m_data_o     (m_data_o),
        .m_valid_o    (m_valid_o),
        .m_ready_i    (m_ready_i),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .count_o      (count_o),
        .underrun_o   (underrun_o)
    );

    always #5 clk_i = ~clk_i;

    logic [DW-1:0] fifo_q[$];
    logic [DW-1:0] exp_q[$];
    int            tests = 0;
    int            fails = 0;
    int            done_cnt = 0;
    int            frame_rd = 0;
    int            frame_hs = 0;
    logic          stall_prev = 1'b0;
    logic [DW-1:0] stall_dat = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural FIFO: data one cycle after the strobe, empty flag registered.
    always @(posedge clk_i) begin
        if (fifo_rd_en_o && fifo_q.size() > 0) begin
            fifo_dout_i <= fifo_q.pop_front();
        end
        fifo_empty_i <= (fifo_q.size() == 0);
    end

    // Monitor: scoreboard pops, stall stability, outstanding-sample limit.
    always @(negedge clk_i) begin
        if (rst_i) begin
            if (start_i && !abort_i && !busy_o) begin
                frame_rd = 0;
                frame_hs = 0;
            end
            if (fifo_rd_en_o) frame_rd++;
            if (done_o) done_cnt++;
            if (stall_prev && m_valid_o) chk("stall_hold", m_data_o, stall_dat);
            if (m_valid_o && m_ready_i) begin
                frame_hs++;
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_sample: got %0d expected none at %0t", m_data_o, $time);
                end else begin
                    chk("sample", m_data_o, exp_q.pop_front());
                end
            end
            if (busy_o) chk("outstanding_le2", 32'(frame_rd - frame_hs <= 2), 1);
            stall_prev = m_valid_o && !m_ready_i;
            stall_dat  = m_data_o;
        end else begin
            stall_prev = 1'b0;
        end
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic start_frame();
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
    endtask

    task automatic wait_done(input int budget, input string name);
        int n = 0;
        while (!done_o && n < budget) begin
            tick();
            n++;
        end
        chk(name, done_o, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int d0;
        int n;
        int k;
        logic [5:0] pat;

        // ---------------- reset ----------------
        repeat (3) tick();
        rst_i = 1'b1;
        tick();
        chk("rst_busy", busy_o, 0);
        chk("rst_rd_en", fifo_rd_en_o, 0);
        chk("rst_valid", m_valid_o, 0);
        chk("rst_count", count_o, 0);
        chk("rst_underrun", underrun_o, 0);

        start_i   = 1'b1;
        m_ready_i = 1'($urandom_range(0, 1));
        repeat (3) tick();
        chk("pre_reset_busy", busy_o, 1);
        chk("pre_reset_underrun", underrun_o, 1);
        #2;
        abort_i = 1'($urandom_range(0, 1));
        rst_i   = 1'b0;
        #1;
        chk("async_busy", busy_o, 0);
        chk("async_underrun", underrun_o, 0);
        chk("async_done", done_o, 0);
        chk("async_rd_en", fifo_rd_en_o, 0);
        chk("async_valid", m_valid_o, 0);
        chk("async_data", m_data_o, 0);
        chk("async_count", count_o, 0);
        tick();
        start_i = 1'b0;
        abort_i = 1'b0;
        rst_i   = 1'b1;
        tick();
        chk("release_busy", busy_o, 0);

        // ---------------- full rate ----------------
        for (int v = 1; v <= 8; v++) begin
            fifo_q.push_back(DW'(v));
            exp_q.push_back(DW'(v));
        end
        tick();
        tick();
        m_ready_i = 1'b1;
        d0 = done_cnt;
        start_frame();
        for (int i = 0; i < 8; i++) begin
            chk("fr_rd_en", fifo_rd_en_o, 1);
            if (i < 2) chk("fr_not_yet_valid", m_valid_o, 0);
            if (i == 2) chk("fr_first_valid", m_valid_o, 1);
            tick();
        end
        chk("fr_rd_en_stop", fifo_rd_en_o, 0);
        wait_done(10, "fr_done");
        chk("fr_busy", busy_o, 0);
        chk("fr_count", count_o, 8);
        chk("fr_underrun", underrun_o, 0);
        tick();
        chk("fr_done_pulse", done_o, 0);
        chk("fr_done_cnt", done_cnt - d0, 1);
        chk("fr_all_delivered", exp_q.size(), 0);

        // ---------------- backpressure ----------------
        pat = 6'b101001;
        for (int v = 21; v <= 28; v++) begin
            fifo_q.push_back(DW'(v));
            exp_q.push_back(DW'(v));
        end
        tick();
        tick();
        d0 = done_cnt;
        m_ready_i = 1'b1;
        start_frame();
        k = 0;
        while (!done_o && k < 100) begin
            m_ready_i = pat[k % 6];
            tick();
            k++;
        end
        chk("bp_done", done_o, 1);
        chk("bp_count", count_o, 8);
        tick();
        chk("bp_done_cnt", done_cnt - d0, 1);
        chk("bp_all_delivered", exp_q.size(), 0);

        // ---------------- underrun ----------------
        for (int v = 31; v <= 33; v++) fifo_q.push_back(DW'(v));
        for (int v = 31; v <= 38; v++) exp_q.push_back(DW'(v));
        tick();
        tick();
        m_ready_i = 1'b1;
        start_frame();
        repeat (12) tick();
        chk("ur_flag", underrun_o, 1);
        chk("ur_busy", busy_o, 1);
        chk("ur_count3", count_o, 3);
        for (int v = 34; v <= 38; v++) fifo_q.push_back(DW'(v));
        wait_done(30, "ur_done");
        chk("ur_count8", count_o, 8);
        chk("ur_flag_sticky", underrun_o, 1);
        tick();
        chk("ur_all_delivered", exp_q.size(), 0);

        // ---------------- abort ----------------
        for (int v = 41; v <= 50; v++) fifo_q.push_back(DW'(v));
        for (int v = 41; v <= 44; v++) exp_q.push_back(DW'(v));
        tick();
        tick();
        m_ready_i = 1'b1;
        d0 = done_cnt;
        start_frame();
        n = 0;
        k = 0;
        while (n < 4 && k < 40) begin
            if (m_valid_o && m_ready_i) n++;
            tick();
            k++;
        end
        chk("ab_four_handshakes", n, 4);
        abort_i   = 1'b1;
        m_ready_i = 1'b0;
        tick();
        abort_i = 1'b0;
        chk("ab_valid_low", m_valid_o, 0);
        chk("ab_data_zero", m_data_o, 0);
        chk("ab_rd_en_low", fifo_rd_en_o, 0);
        chk("ab_busy_drain", busy_o, 1);
        chk("ab_underrun_cleared", underrun_o, 0);
        tick();
        chk("ab_busy_idle", busy_o, 0);
        chk("ab_count", count_o, 4);
        chk("ab_no_done", done_cnt - d0, 0);
        // 41..46 were read before the abort; the next frame starts at 47.
        for (int v = 47; v <= 54; v++) exp_q.push_back(DW'(v));
        for (int v = 51; v <= 54; v++) fifo_q.push_back(DW'(v));
        tick();
        m_ready_i = 1'b1;
        start_frame();
        wait_done(40, "ab_restart_done");
        chk("ab_restart_count", count_o, 8);
        chk("ab_restart_underrun", underrun_o, 0);
        tick();
        chk("ab_restart_delivered", exp_q.size(), 0);

        // ---------------- start and abort together in IDLE ----------------
        fifo_q.push_back(DW'(60));
        tick();
        tick();
        start_i = 1'b1;
        abort_i = 1'b1;
        tick();
        start_i = 1'b0;
        abort_i = 1'b0;
        chk("sa_busy", busy_o, 0);
        chk("sa_rd_en", fifo_rd_en_o, 0);
        tick();
        chk("sa_busy_later", busy_o, 0);
        chk("sa_rd_en_later", fifo_rd_en_o, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
